// File: rtl/sha256_mem_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
// The responder owns a 128-word RAM that the host fills with message words
// and the hasher later reads and writes through its own memory port.
package sha256_mem_pkg;

    localparam int DEPTH      = 128;
    localparam int ADDR_W     = 7;
    localparam int HASH_WORDS = 8;

    localparam logic [15:0] DEFAULT_MSG_BASE = 16'h0000;
    localparam logic [15:0] DEFAULT_OUT_BASE = 16'h0040;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/sha256_mem_responder_if.sv
// Bundle of the host streams, hasher control and hasher memory port.
// The responder uses the slave view; the surrounding system uses master.
interface sha256_mem_responder_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        done;

    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        busy;
    logic        error;

    modport slave (
        input  in_valid, in_data, out_ready, done, mem_we, mem_addr, mem_write_data,
        output in_ready, out_valid, out_data, start, message_addr, output_addr,
               mem_read_data, busy, error
    );

    modport master (
        output in_valid, in_data, out_ready, done, mem_we, mem_addr, mem_write_data,
        input  in_ready, out_valid, out_data, start, message_addr, output_addr,
               mem_read_data, busy, error
    );

endinterface

// File: rtl/sha256_sp_ram.sv
// Single-port RAM: synchronous write, registered read that returns the
// contents from before a same-cycle write. The array itself is never
// cleared, so an aborted job leaves earlier results in place.
module sha256_sp_ram
    import sha256_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Write port; storage has no reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register, cleared so the visible read data starts at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory responder sitting between a host and a SHA-256 hasher.
// A job loads NUM_OF_WORDS message words, pulses start, serves the hasher's
// memory port until done rises, then streams the 8 hash words to the host.
// Optional build macro SHA_MEM_ERR_EN: hasher addresses at or above 128 read
// zero, drop writes and set a sticky error; without it addresses wrap.
module sha256_mem_responder
    import sha256_mem_pkg::*;
#(
    parameter int          NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = DEFAULT_MSG_BASE,
    parameter logic [15:0] OUT_BASE     = DEFAULT_OUT_BASE
) (
    input logic                   clk,
    input logic                   reset,
    sha256_mem_responder_if.slave bus
);

    state_t            state;
    state_t            state_next;
    logic [6:0]        word_cnt;
    logic [2:0]        hash_idx;
    logic              out_valid_q;
    logic              done_q;
    logic              rd_fault_q;
    logic              error_q;
    logic              addr_fault;
    logic              load_fire;
    logic              last_word;
    logic              drain_fire;
    logic              done_rise;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    assign load_fire  = (state == ST_LOAD) && bus.in_valid;
    assign last_word  = (word_cnt == 7'(NUM_OF_WORDS - 1));
    assign drain_fire = (state == ST_DRAIN) && out_valid_q && bus.out_ready;
    assign done_rise  = bus.done && !done_q;

`ifdef SHA_MEM_ERR_EN
    assign addr_fault = (state == ST_WAIT) && (bus.mem_addr[15:ADDR_W] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[15:ADDR_W];
    assign addr_fault     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and RAM port ownership by state.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        bus.start    = 1'b0;
        bus.busy     = 1'b1;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = bus.in_data;
        unique case (state)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                ram_we       = bus.in_valid;
                ram_addr     = MSG_BASE[ADDR_W-1:0] + word_cnt;
                if (load_fire && last_word) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                bus.start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ram_we    = bus.mem_we && !addr_fault;
                ram_addr  = bus.mem_addr[ADDR_W-1:0];
                ram_wdata = bus.mem_write_data;
                if (done_rise) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ram_addr = OUT_BASE[ADDR_W-1:0] + {4'b0000, hash_idx};
                if (drain_fire && (hash_idx == 3'(HASH_WORDS - 1))) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Message word index; restarts once the last word of a job is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (load_fire) begin
            word_cnt <= last_word ? 7'd0 : word_cnt + 7'd1;
        end
    end

    // Drain sequencing: one cycle to read a hash word, then hold it until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hash_idx    <= '0;
            out_valid_q <= 1'b0;
        end else if (state == ST_DRAIN) begin
            if (drain_fire) begin
                out_valid_q <= 1'b0;
                hash_idx    <= hash_idx + 3'd1;
            end else if (!out_valid_q) begin
                out_valid_q <= 1'b1;
            end
        end
    end

    // Done edge history, read-fault tag for the read register, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q     <= 1'b0;
            rd_fault_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q     <= bus.done;
            rd_fault_q <= addr_fault;
            if (addr_fault) begin
                error_q <= 1'b1;
            end
        end
    end

    sha256_sp_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_valid_q ? ram_rdata : 32'h0;
    assign bus.mem_read_data = rd_fault_q ? 32'h0 : ram_rdata;
    assign bus.message_addr  = MSG_BASE;
    assign bus.output_addr   = OUT_BASE;
    assign bus.error         = error_q;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Bench for sha256_mem_responder: table-driven hasher memory-port vectors,
// hand-written load/drain/reset sequences, and randomized jobs whose drained
// digest is compared with a SHA-256 reference computed from the host words.
module tb_sha256_mem_responder;

    localparam int          NW    = 20;
    localparam logic [15:0] MSG_B = 16'h0000;
    localparam logic [15:0] OUT_B = 16'h0040;

`ifdef SHA_MEM_ERR_EN
    localparam logic        ERR_EXP  = 1'b1;
    localparam logic [31:0] HI_RD0   = 32'h0000_0000;
    localparam logic [31:0] HI_RD5   = 32'd5;
`else
    localparam logic        ERR_EXP  = 1'b0;
    localparam logic [31:0] HI_RD0   = 32'hCAFE_0000;
    localparam logic [31:0] HI_RD5   = 32'hBAD0_BAD0;
`endif

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
    } mem_vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] host_words [NW];
    logic [31:0] exp_out [8];
    logic [255:0] prev_digest;
    logic [255:0] hasher_digest;
    mem_vec_t    tbl [19];

    sha256_mem_responder_if bus ();

    sha256_mem_responder #(
        .NUM_OF_WORDS (NW),
        .MSG_BASE     (MSG_B),
        .OUT_BASE     (OUT_B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic mem_vec_t mk(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                    input logic chk, input logic [31:0] exp_rd);
        mem_vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp_rd = exp_rd;
        return v;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 of a 20-word (640-bit) message, two padded blocks.
    function automatic logic [255:0] sha256_20(input logic [639:0] msg);
        logic [1023:0] p;
        logic [31:0] w [64];
        logic [31:0] h [8];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        p = {msg, 32'h8000_0000, 320'h0, 32'd640};
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < 2; blk++) begin
            for (int t = 0; t < 16; t++) w[t] = p[1023 - 512*blk - 32*t -: 32];
            for (int t = 16; t < 64; t++) begin
                s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] model_digest();
        logic [639:0] m;
        for (int i = 0; i < NW; i++) m[639 - 32*i -: 32] = host_words[i];
        return sha256_20(m);
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // One hasher memory-port cycle; read data is visible at the following negedge.
    task automatic apply_stimulus(input mem_vec_t v);
        bus.mem_we         = v.we;
        bus.mem_addr       = v.addr;
        bus.mem_write_data = v.wdata;
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    // Host load of NW words, optionally with random idle gaps; in_valid stays high afterwards.
    task automatic load_job(input bit gaps, input string tag);
        int   acc = 0;
        int   cyc = 0;
        logic v;
        while (acc < NW && cyc < 400) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = v ? host_words[acc] : $urandom;
            check_bit({tag, "_in_ready_load"}, bus.in_ready, 1'b1);
            if (v) acc++;
            @(negedge clk);
            cyc++;
        end
        if (acc < NW) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_load_timeout: accepted %0d, required %0d", tag, acc, NW);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        check_bit({tag, "_start_pulse"}, bus.start, 1'b1);
        check_bit({tag, "_in_ready_after_last"}, bus.in_ready, 1'b0);
        check_bit({tag, "_busy_in_start"}, bus.busy, 1'b1);
        @(negedge clk);
        check_bit({tag, "_start_one_cycle"}, bus.start, 1'b0);
        check_bit({tag, "_in_ready_wait"}, bus.in_ready, 1'b0);
    endtask

    // Behaves like the hasher: read the message, write its digest to the output area.
    task automatic run_hasher(output logic [255:0] dig);
        logic [639:0] m;
        bus.mem_we = 1'b0;
        for (int i = 0; i < NW; i++) begin
            bus.mem_addr = MSG_B + 16'(i);
            @(negedge clk);
            m[639 - 32*i -: 32] = bus.mem_read_data;
        end
        dig = sha256_20(m);
        for (int k = 0; k < 8; k++) begin
            bus.mem_we         = 1'b1;
            bus.mem_addr       = OUT_B + 16'(k);
            bus.mem_write_data = dig[255 - 32*k -: 32];
            @(negedge clk);
        end
        bus.mem_we   = 1'b0;
        bus.mem_addr = 16'h0000;
    endtask

    task automatic pulse_done();
        bus.done = 1'b0;
        @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
    endtask

    // Collect 8 hash words, checking order, hold-while-stalled and the gap after each take.
    task automatic drain_check(input int stall_idx, input bit rnd, input string tag);
        int          got    = 0;
        int          cyc    = 0;
        int          stalls = 0;
        logic        prev_v = 1'b0;
        logic        prev_r = 1'b0;
        logic        rdy;
        logic [31:0] prev_d = 32'h0;
        while (got < 8 && cyc < 200) begin
            if (prev_v && !prev_r) begin
                check_bit($sformatf("%s_hold_valid%0d", tag, got), bus.out_valid, 1'b1);
                check_output($sformatf("%s_hold_data%0d", tag, got), bus.out_data, prev_d);
            end else if (prev_v && prev_r) begin
                check_bit($sformatf("%s_gap%0d", tag, got), bus.out_valid, 1'b0);
            end
            rdy = 1'b0;
            if (bus.out_valid) begin
                if (got == stall_idx && stalls < 3) begin
                    stalls++;
                end else if (!rnd || $urandom_range(0, 2) != 0) begin
                    check_output($sformatf("%s_word%0d", tag, got), bus.out_data, exp_out[got]);
                    rdy = 1'b1;
                    got++;
                end
            end
            prev_v        = bus.out_valid;
            prev_r        = rdy;
            prev_d        = bus.out_data;
            bus.out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < 8) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s_drain_timeout: drained %0d, required 8", tag, got);
        end
        check_bit({tag, "_out_valid_after_last"}, bus.out_valid, 1'b0);
        check_bit({tag, "_busy_after_drain"}, bus.busy, 1'b0);
        check_bit({tag, "_in_ready_after_drain"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        tbl[0]  = mk(1'b0, 16'h0005, 32'h0,          1'b1, 32'd5);
        tbl[1]  = mk(1'b0, 16'h0013, 32'h0,          1'b1, 32'd19);
        tbl[2]  = mk(1'b1, 16'h0040, 32'hDEAD_BEEF,  1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 16'h0040, 32'h0,          1'b1, 32'hDEAD_BEEF);
        tbl[4]  = mk(1'b1, 16'h0041, 32'h0000_1234,  1'b0, 32'h0);
        tbl[5]  = mk(1'b1, 16'h0041, 32'h0000_5678,  1'b1, 32'h0000_1234);
        tbl[6]  = mk(1'b0, 16'h0041, 32'h0,          1'b1, 32'h0000_5678);
        tbl[7]  = mk(1'b1, 16'h0000, 32'hCAFE_0000,  1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 16'h0200, 32'h0,          1'b1, HI_RD0);
        tbl[9]  = mk(1'b1, 16'h0205, 32'hBAD0_BAD0,  1'b0, 32'h0);
        tbl[10] = mk(1'b0, 16'h0005, 32'h0,          1'b1, HI_RD5);
        for (int k = 0; k < 8; k++) begin
            tbl[11 + k] = mk(1'b1, OUT_B + 16'(k), 32'h1111_1111 * 32'(k + 1), 1'b0, 32'h0);
        end

        bus.in_valid       = 1'b0;
        bus.in_data        = 32'h0;
        bus.out_ready      = 1'b0;
        bus.done           = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = 16'h0;
        bus.mem_write_data = 32'h0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_start", bus.start, 1'b0);
        check_bit("reset_out_valid", bus.out_valid, 1'b0);
        check_bit("reset_error", bus.error, 1'b0);
        check_output("reset_mem_read_data", bus.mem_read_data, 32'h0);
        check_output("reset_out_data", bus.out_data, 32'h0);
        check_output("message_addr", {16'h0, bus.message_addr}, {16'h0, MSG_B});
        check_output("output_addr", {16'h0, bus.output_addr}, {16'h0, OUT_B});
        reset = 1'b0;
        @(negedge clk);
        check_bit("in_ready_after_release", bus.in_ready, 1'b1);

        // Job 1: counting words, stray hasher write during load, done already high at WAIT entry.
        for (int i = 0; i < NW; i++) host_words[i] = 32'(i);
        bus.done           = 1'b1;
        bus.mem_we         = 1'b1;
        bus.mem_addr       = 16'h0005;
        bus.mem_write_data = 32'hFFFF_0000;
        load_job(1'b0, "job1");
        bus.mem_we   = 1'b0;
        bus.mem_addr = 16'h0;
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(tbl[i]);
            if (tbl[i].chk) check_output($sformatf("mem_vec%0d", i), bus.mem_read_data, tbl[i].exp_rd);
        end
        check_bit("error_flag", bus.error, ERR_EXP);
        check_bit("level_done_no_drain", bus.out_valid, 1'b0);
        check_bit("level_done_still_busy", bus.busy, 1'b1);
        check_bit("in_ready_ignored_wait", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        pulse_done();
        for (int k = 0; k < 8; k++) exp_out[k] = 32'h1111_1111 * 32'(k + 1);
        drain_check(2, 1'b0, "job1");
        check_bit("error_sticky", bus.error, ERR_EXP);

        // Job 2: random words with gaps, emulated hasher, random host back-pressure.
        for (int i = 0; i < NW; i++) host_words[i] = $urandom;
        load_job(1'b1, "job2");
        bus.in_valid = 1'b0;
        run_hasher(hasher_digest);
        prev_digest = model_digest();
        for (int k = 0; k < 8; k++) exp_out[k] = prev_digest[255 - 32*k -: 32];
        pulse_done();
        drain_check(-1, 1'b1, "job2");

        // Job 3: abandoned by reset while waiting on the hasher.
        for (int i = 0; i < NW; i++) host_words[i] = $urandom;
        load_job(1'b0, "job3");
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_bit("midjob_reset_start", bus.start, 1'b0);
        check_bit("midjob_reset_out_valid", bus.out_valid, 1'b0);
        check_bit("midjob_reset_busy", bus.busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_bit("midjob_in_ready_after_release", bus.in_ready, 1'b1);

        // Job 4: fresh load after the abort; earlier digest must still be in RAM.
        for (int i = 0; i < NW; i++) host_words[i] = $urandom;
        load_job(1'b1, "job4");
        bus.in_valid = 1'b0;
        apply_stimulus(mk(1'b0, OUT_B, 32'h0, 1'b1, 32'h0));
        check_output("ram_kept_over_reset", bus.mem_read_data, prev_digest[255 -: 32]);
        run_hasher(hasher_digest);
        prev_digest = model_digest();
        for (int k = 0; k < 8; k++) exp_out[k] = prev_digest[255 - 32*k -: 32];
        pulse_done();
        drain_check(5, 1'b1, "job4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha256_mem_responder.md
SHA256_MEM_RESPONDER -- requirements
Module: sha256_mem_responder

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, message words loaded per job (1..64).
REQ-002 SHALL have parameter MSG_BASE, default 16'h0000, message word address given to hasher.
REQ-003 SHALL have parameter OUT_BASE, default 16'h0040, hash output word address given to hasher.
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid in 1, in_data in 32, in_ready out 1: host message-word stream.
REQ-007 SHALL have ports out_valid out 1, out_data out 32, out_ready in 1: hash-word stream to host.
REQ-008 SHALL have ports start out 1, message_addr out 16, output_addr out 16, done in 1: hasher control.
REQ-009 SHALL have ports mem_we in 1, mem_addr in 16, mem_write_data in 32, mem_read_data out 32: hasher memory port.
REQ-010 SHALL have ports busy out 1 (state != LOAD) and error out 1 (sticky address fault).

Function
REQ-011 SHALL hold 128x32 words in a RAM; message_addr=MSG_BASE, output_addr=OUT_BASE, held constant.
REQ-012 SHALL implement FSM LOAD -> START -> WAIT -> DRAIN -> LOAD.
REQ-013 LOAD: in_ready=1; each in_valid&&in_ready writes in_data to MSG_BASE+n, n=0..NUM_OF_WORDS-1; after word NUM_OF_WORDS-1 -> START, in_ready=0 from the next cycle.
REQ-014 START: start=1 for exactly one cycle, then -> WAIT.
REQ-015 WAIT: read response registered, mem_read_data = RAM[mem_addr sampled at edge N], valid after edge N (1-cycle latency).
REQ-016 WAIT: mem_we=1 writes mem_write_data to RAM[mem_addr] at edge; read-during-write same address returns old data.
REQ-017 Hasher-port writes outside WAIT SHALL be ignored, no error.
REQ-018 WAIT -> DRAIN on rising edge of done (registered previous value); level-high done on WAIT entry SHALL NOT trigger.
REQ-019 DRAIN: read OUT_BASE+j, j=0..7; out_valid=1 the cycle after each read issues; out_data stable while out_valid&&!out_ready.
REQ-020 DRAIN: on handshake with j<7, out_valid=0 one cycle while next read issues (1 word / 2 cycles max); after j=7 handshake -> LOAD, out_valid=0.
REQ-021 in_valid outside LOAD SHALL be ignored (in_ready=0, no data consumed).

Reset
REQ-022 Reset SHALL force LOAD, n=j=0, start=0, out_valid=0, in_ready=1 after release, busy=0, error=0, mem_read_data=0, out_data=0.
REQ-023 Reset mid-job SHALL abandon the job; RAM contents not cleared.

Configuration
REQ-024 With SHA_MEM_ERR_EN defined: hasher-port access in WAIT with mem_addr >= 128 SHALL read 0, drop writes, set error until reset.
REQ-025 Without SHA_MEM_ERR_EN: mem_addr SHALL wrap modulo 128 (bits [6:0]); error tied 0.

Structure
REQ-026 Package sha256_mem_pkg SHALL hold the state enum, DEPTH=128, HASH_WORDS=8, default MSG_BASE/OUT_BASE.
REQ-027 RAM SHALL be sub-module sha256_sp_ram (single port, sync write, registered read); port mux by state in the parent.

Verification
REQ-028 Load words 0..19 with in_valid held high -> 20 handshakes, in_ready=0 next cycle, start=1 exactly one cycle after.
REQ-029 WAIT, mem_addr=5 at edge N -> mem_read_data=32'd5 after edge N; mem_we, addr 0x40, data 32'hDEADBEEF -> later read of 0x40 returns 32'hDEADBEEF.
REQ-030 Hasher writes 32'h11111111..32'h88888888 to 0x40..0x47, done 0->1 -> 8 words out in order; out_ready low 3 cycles -> out_data unchanged, out_valid held.
REQ-031 With SHA_MEM_ERR_EN: WAIT read at 16'h0200 -> mem_read_data=0, error=1 and stays 1; without: returns RAM[0x00].
REQ-032 Reset asserted in WAIT -> start=0, out_valid=0, busy=0 immediately; in_ready=1 after release; new 20-word load accepted.
REQ-033 Drive the team's SHA-256 hasher with 20 message words -> drained 8 words equal reference-model digest.
